spi_flash_seq: RTL and testbench
================================

Name: spi_flash_seq

Overview:
- Command sequencer sitting between the hw_test control logic and the SPI byte engine that drives S/DQ to the serial NOR flash.
- Turns one high-level request (READ, PAGE_PROG, SECTOR_ERASE, READ_SR) into the full byte sequence: WREN, opcode, 24-bit address, data phase, and RDSR polling of WIP until the flash is idle.
- Handles one command at a time and reports completion and error status.

Parameters:
- LEN_W, 16, width of cmd_len; bytes transferred = cmd_len+1
- OP_READ, 8'h03, read opcode
- OP_PP, 8'h02, page program opcode
- OP_SE, 8'hD8, sector erase opcode
- OP_WREN, 8'h06, write enable opcode
- OP_RDSR, 8'h05, read status register opcode
- TIMEOUT, 24'd10_000_000, max RDSR polls (used only with SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  0=READ, 1=PAGE_PROG, 2=SECTOR_ERASE, 3=READ_SR
- cmd_addr  in  24  flash byte address
- cmd_len  in  LEN_W  byte count minus 1 (READ, PAGE_PROG)
- wr_data  in  8  program data
- wr_valid  in  1  program data valid
- wr_ready  out  1  wr_data consumed this cycle
- rd_data  out  8  read/status byte
- rd_valid  out  1  1-cycle strobe, no backpressure
- eng_req  out  1  byte transfer request to SPI engine
- eng_tx  out  8  byte to shift out
- eng_last  out  1  engine deasserts S after this byte
- eng_ack  in  1  1-cycle pulse, byte complete; eng_rx valid
- eng_rx  in  8  byte shifted in
- busy  out  1  not IDLE
- done  out  1  1-cycle pulse at command end
- err  out  1  sticky error, cleared on next accepted command

Behaviour:
- Reset: state=IDLE; cmd_ready=1; all other outputs 0.
- Engine handshake:
  - eng_req, eng_tx and eng_last stay stable from assertion until the cycle eng_ack=1.
  - eng_req drops the cycle after eng_ack.
  - The next request is issued no earlier than 1 cycle later.
- Accept: cmd_valid&&cmd_ready latches op/addr/len and clears err; busy=1 the next cycle.
- States: IDLE, WREN, OPC, A2, A1, A0, DATA, POLL_OPC, POLL_RD, DONE.
- Sequences:
  - READ: OPC(03), A2, A1, A0, DATA×(len+1); eng_tx=00 in DATA; each eng_ack gives rd_data=eng_rx with rd_valid; last DATA byte sets eng_last.
  - PAGE_PROG: WREN(06, last), OPC(02), A2, A1, A0, DATA×(len[7:0]+1), then POLL.
    - len bits above 7 are ignored (max 256 bytes).
    - In DATA, eng_req asserts only when wr_valid=1; wr_ready pulses in the cycle eng_req is first raised for that byte.
    - A stalled wr_valid stalls the sequence with S held low.
  - SECTOR_ERASE: WREN, OPC(D8), A2, A1, A0(last), then POLL.
  - READ_SR: POLL_OPC(05), POLL_RD(last); status returned on rd_data/rd_valid; then DONE.
- POLL: POLL_OPC(05) then POLL_RD(00, last).
  - If eng_rx[0]=1 (WIP), return to POLL_OPC.
  - Else DONE. Poll status bytes are not forwarded on rd_valid.
- Address order is MSB first: A2=addr[23:16], A1=addr[15:8], A0=addr[7:0].
- Byte counter decrements on DATA eng_ack; DATA exits when the counter reaches 0 on ack. len=0 transfers exactly 1 byte.
- DONE: done=1 for 1 cycle, then IDLE.
- cmd_valid while busy is ignored (cmd_ready=0).
- rst mid-operation returns to IDLE within 1 cycle and drops eng_req. The engine is responsible for deasserting S on rst.

Optional Feature:
- SEQ_TIMEOUT_EN defined:
  - A 24-bit poll counter clears on entry to POLL and increments per POLL_RD ack.
  - When the counter reaches TIMEOUT with WIP still 1: err=1, go to DONE (done pulses).
- Undefined: the counter is not built, polling is unbounded, and err stays 0.

Test Plan:
- Reset, then READ addr=24'h012345, len=3, engine model returns AA,BB,CC,DD -> eng_tx seq 03,01,23,45,00×4; eng_last only on 4th data byte; rd_data AA,BB,CC,DD with 4 rd_valid; one done.
- PAGE_PROG addr=24'h000100, len=1, wr_data 5A,A5; RDSR model returns 03,03,00 -> tx 06(last) | 02,00,01,00,5A,A5(last) | 05,00 ×3; 2 wr_ready; done after 3rd poll; no rd_valid.
- SECTOR_ERASE addr=24'h010000 -> tx 06(last) | D8,01,00,00(last) | poll; err=0.
- wr_valid held low 20 cycles mid PAGE_PROG -> eng_req low, eng_last 0, no S release; resumes on wr_valid with correct byte.
- rst pulsed during A1 of READ -> next cycle busy=0, eng_req=0, cmd_ready=1; a following READ_SR returns rd_data=eng_rx once.
- With SEQ_TIMEOUT_EN and TIMEOUT=5, WIP stuck at 1 -> exactly 5 RDSR sequences, then err=1 and done pulse; next command clears err.

Source files
------------

// File: rtl/spi_flash_seq.sv
// SPI NOR command sequencer: expands READ / PAGE_PROG / SECTOR_ERASE / READ_SR into engine byte transfers.
// Define SEQ_TIMEOUT_EN to bound RDSR polling by TIMEOUT and flag err on expiry.
module spi_flash_seq #(
  parameter int unsigned LEN_W   = 16,
  parameter logic [7:0]  OP_READ = 8'h03,
  parameter logic [7:0]  OP_PP   = 8'h02,
  parameter logic [7:0]  OP_SE   = 8'hD8,
  parameter logic [7:0]  OP_WREN = 8'h06,
  parameter logic [7:0]  OP_RDSR = 8'h05,
  parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [23:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             eng_req,
  output logic [7:0]       eng_tx,
  output logic             eng_last,
  input  logic             eng_ack,
  input  logic [7:0]       eng_rx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [3:0] {
    S_IDLE, S_WREN, S_OPC, S_A2, S_A1, S_A0, S_DATA, S_POLL_OPC, S_POLL_RD, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    C_READ = 2'd0, C_PP = 2'd1, C_SE = 2'd2, C_RDSR = 2'd3
  } cmd_t;

  state_t           r_state, w_state_nxt;
  cmd_t             r_op, w_op_nxt;
  cmd_t             w_cmd_op;
  logic [23:0]      r_addr, w_addr_nxt;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_eng_req, w_eng_req_nxt;
  logic [7:0]       r_eng_tx, w_eng_tx_nxt;
  logic             r_eng_last, w_eng_last_nxt;
  logic             r_wr_ready, w_wr_ready_nxt;
  logic [7:0]       r_rd_data, w_rd_data_nxt;
  logic             r_rd_valid, w_rd_valid_nxt;

  logic             w_accept;
  logic             w_ack;
  logic             w_poll_ack;
  logic             w_timeout;
  logic             w_has_byte;
  logic [7:0]       w_byte;
  logic             w_byte_last;

  assign w_cmd_op   = cmd_t'(cmd_op);
  assign w_accept   = (r_state == S_IDLE) && cmd_valid;
  // Only an ack against an outstanding request advances the sequence.
  assign w_ack      = r_eng_req && eng_ack;
  assign w_poll_ack = (r_state == S_POLL_RD) && w_ack && (r_op != C_RDSR);

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign eng_req   = r_eng_req;
  assign eng_tx    = r_eng_tx;
  assign eng_last  = r_eng_last;
  assign wr_ready  = r_wr_ready;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;

  always_ff @(posedge clk) begin
    // NOTE: every register here is a handful of flops, so all of them take the reset value.
    if (rst) begin
      r_state    <= S_IDLE;
      r_op       <= C_READ;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_eng_req  <= 1'b0;
      r_eng_tx   <= 8'h00;
      r_eng_last <= 1'b0;
      r_wr_ready <= 1'b0;
      r_rd_data  <= 8'h00;
      r_rd_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value of the others.
      r_state    <= w_state_nxt;
      r_op       <= w_op_nxt;
      r_addr     <= w_addr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_eng_req  <= w_eng_req_nxt;
      r_eng_tx   <= w_eng_tx_nxt;
      r_eng_last <= w_eng_last_nxt;
      r_wr_ready <= w_wr_ready_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_rd_valid <= w_rd_valid_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
    w_state_nxt    = r_state;
    w_op_nxt       = r_op;
    w_addr_nxt     = r_addr;
    w_cnt_nxt      = r_cnt;
    w_eng_req_nxt  = r_eng_req;
    w_eng_tx_nxt   = r_eng_tx;
    w_eng_last_nxt = r_eng_last;
    w_wr_ready_nxt = 1'b0;
    w_rd_data_nxt  = r_rd_data;
    w_rd_valid_nxt = 1'b0;
    w_byte         = 8'h00;
    w_byte_last    = 1'b0;
    w_has_byte     = 1'b0;

    // Byte each transfer state wants to send, and whether it is available yet.
    case (r_state)
      S_WREN: begin
        w_byte      = OP_WREN;
        w_byte_last = 1'b1;
        w_has_byte  = 1'b1;
      end
      S_OPC: begin
        w_byte     = (r_op == C_READ) ? OP_READ : ((r_op == C_PP) ? OP_PP : OP_SE);
        w_has_byte = 1'b1;
      end
      S_A2: begin
        w_byte     = r_addr[23:16];
        w_has_byte = 1'b1;
      end
      S_A1: begin
        w_byte     = r_addr[15:8];
        w_has_byte = 1'b1;
      end
      S_A0: begin
        w_byte      = r_addr[7:0];
        w_byte_last = (r_op == C_SE);
        w_has_byte  = 1'b1;
      end
      S_DATA: begin
        w_byte      = (r_op == C_PP) ? wr_data : 8'h00;
        w_byte_last = (r_cnt == '0);
        w_has_byte  = (r_op != C_PP) || wr_valid;
      end
      S_POLL_OPC: begin
        w_byte     = OP_RDSR;
        w_has_byte = 1'b1;
      end
      S_POLL_RD: begin
        w_byte      = 8'h00;
        w_byte_last = 1'b1;
        w_has_byte  = 1'b1;
      end
      default: ;
    endcase

    // A request goes out only while none is outstanding, so after an ack the
    // line stays low for one cycle before the next byte is requested.
    if (!r_eng_req && w_has_byte) begin
      w_eng_req_nxt  = 1'b1;
      w_eng_tx_nxt   = w_byte;
      w_eng_last_nxt = w_byte_last;
      w_wr_ready_nxt = (r_state == S_DATA) && (r_op == C_PP);
    end

    if (w_ack) begin
      w_eng_req_nxt  = 1'b0;
      w_eng_last_nxt = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_op_nxt   = w_cmd_op;
          w_addr_nxt = cmd_addr;
          // Page programs wrap at 256 bytes, so only the low length byte counts.
          w_cnt_nxt  = (w_cmd_op == C_PP) ? LEN_W'(cmd_len[7:0]) : cmd_len;
          case (w_cmd_op)
            C_READ:  w_state_nxt = S_OPC;
            C_RDSR:  w_state_nxt = S_POLL_OPC;
            default: w_state_nxt = S_WREN;
          endcase
        end
      end
      S_WREN: if (w_ack) w_state_nxt = S_OPC;
      S_OPC:  if (w_ack) w_state_nxt = S_A2;
      S_A2:   if (w_ack) w_state_nxt = S_A1;
      S_A1:   if (w_ack) w_state_nxt = S_A0;
      S_A0:   if (w_ack) w_state_nxt = (r_op == C_SE) ? S_POLL_OPC : S_DATA;
      S_DATA: begin
        if (w_ack) begin
          if (r_op == C_READ) begin
            w_rd_valid_nxt = 1'b1;
            w_rd_data_nxt  = eng_rx;
          end
          if (r_cnt == '0) begin
            w_state_nxt = (r_op == C_PP) ? S_POLL_OPC : S_DONE;
          end else begin
            w_cnt_nxt = r_cnt - LEN_W'(1);
          end
        end
      end
      S_POLL_OPC: if (w_ack) w_state_nxt = S_POLL_RD;
      S_POLL_RD: begin
        if (w_ack) begin
          if (r_op == C_RDSR) begin
            w_rd_valid_nxt = 1'b1;
            w_rd_data_nxt  = eng_rx;
            w_state_nxt    = S_DONE;
          end else if (eng_rx[0] && !w_timeout) begin
            w_state_nxt = S_POLL_OPC;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef SEQ_TIMEOUT_EN
  logic [23:0] r_poll_cnt;
  logic        r_err;

  // Expires on the ack that would make the count of busy polls reach TIMEOUT.
  assign w_timeout = ({1'b0, r_poll_cnt} + 25'd1) >= {1'b0, TIMEOUT};
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_poll_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_poll_ack && eng_rx[0] && w_timeout) begin
        r_err <= 1'b1;
      end
      if (r_state != S_POLL_OPC && r_state != S_POLL_RD) begin
        r_poll_cnt <= '0;
      end else if (w_poll_ack && eng_rx[0]) begin
        r_poll_cnt <= r_poll_cnt + 24'd1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_flash_seq.sv
// Directed bench for spi_flash_seq with a byte-engine model, a write-data source and an output monitor.
// The timeout scenario runs only when SEQ_TIMEOUT_EN is defined.
module tb_spi_flash_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [23:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        eng_req;
  logic [7:0]  eng_tx;
  logic        eng_last;
  logic        eng_ack;
  logic [7:0]  eng_rx;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  spi_flash_seq #(.TIMEOUT(24'd5)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .eng_req(eng_req), .eng_tx(eng_tx), .eng_last(eng_last),
    .eng_ack(eng_ack), .eng_rx(eng_rx),
    .busy(busy), .done(done), .err(err)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_log[$];
  bit         last_log[$];
  logic [7:0] rd_log[$];
  logic [7:0] wr_q[$];
  logic [7:0] exp_tx[$];
  bit         exp_last[$];
  logic [7:0] exp_rd[$];
  int         eng_lat   = 1;
  bit         wip_stuck = 1'b0;
  bit         rst_test  = 1'b0;
  int         hs_bad    = 0;
  int         wr_cnt    = 0;
  int         wr_pop    = 0;
  int         wr_limit  = 0;
  int         done_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Engine model: acks each request after eng_lat cycles and checks the handshake rules.
  initial begin : engine
    logic [7:0] t0;
    logic       l0;
    bit         lost;
    eng_ack = 1'b0;
    eng_rx  = 8'h00;
    forever begin
      tick();
      if (eng_ack) begin
        eng_ack = 1'b0;
        if (eng_req) hs_bad++;
      end else if (eng_req) begin
        t0   = eng_tx;
        l0   = eng_last;
        lost = 1'b0;
        for (int i = 0; i < eng_lat; i++) begin
          tick();
          if (!eng_req) begin
            lost = 1'b1;
            break;
          end
          if (eng_tx !== t0 || eng_last !== l0) hs_bad++;
        end
        if (lost) begin
          if (!rst_test) hs_bad++;
        end else begin
          if (rx_q.size() > 0) eng_rx = rx_q.pop_front();
          else                 eng_rx = wip_stuck ? 8'h01 : 8'h00;
          eng_ack = 1'b1;
          tx_log.push_back(t0);
          last_log.push_back(l0);
        end
      end
    end
  end

  // Write-data source: presents wr_q in order, releasing at most wr_limit bytes.
  initial begin : source
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    forever begin
      tick();
      if (wr_valid && wr_ready) begin
        void'(wr_q.pop_front());
        wr_pop++;
      end
      wr_valid = (wr_pop < wr_limit) && (wr_q.size() > 0);
      wr_data  = (wr_q.size() > 0) ? wr_q[0] : 8'h00;
    end
  end

  initial begin : monitor
    forever begin
      tick();
      if (rd_valid) rd_log.push_back(rd_data);
      if (wr_ready) wr_cnt++;
      if (done)     done_cnt++;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_logs();
    tx_log.delete();
    last_log.delete();
    rd_log.delete();
    rx_q.delete();
    wr_q.delete();
    exp_rd.delete();
    wr_cnt   = 0;
    wr_pop   = 0;
    wr_limit = 0;
    done_cnt = 0;
  endtask

  task automatic push_n(input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) rx_q.push_back(v);
  endtask

  task automatic issue(input logic [1:0] op, input logic [23:0] a, input logic [15:0] len);
    int k = 0;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_len   = len;
    cmd_valid = 1'b1;
    while (!cmd_ready && k < 100) begin
      tick();
      k++;
    end
    tick();
    cmd_valid = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done_cnt < 1 && k < 3000) begin
      tick();
      k++;
    end
    tick();
    tick();
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_idle"}, cmd_ready, 1);
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_ntx"}, tx_log.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++) begin
      check($sformatf("%s_tx%0d", tag, i), tx_log[i], exp_tx[i]);
      check($sformatf("%s_last%0d", tag, i), last_log[i], exp_last[i]);
    end
    check({tag, "_nrd"}, rd_log.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++) begin
      check($sformatf("%s_rd%0d", tag, i), rd_log[i], exp_rd[i]);
    end
  endtask

  initial begin : main
    int k;
    int stall_bad;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_addr  = 24'h0;
    cmd_len   = 16'h0;
    repeat (3) tick();

    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_eng_req", eng_req, 0);
    check("rst_eng_tx", eng_tx, 0);
    check("rst_eng_last", eng_last, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    tick();

    // READ, 4 bytes
    clear_logs();
    eng_lat = 1;
    push_n(4, 8'h00);
    rx_q.push_back(8'hAA); rx_q.push_back(8'hBB);
    rx_q.push_back(8'hCC); rx_q.push_back(8'hDD);
    issue(2'd0, 24'h012345, 16'd3);
    wait_done("rd4");
    exp_tx   = '{8'h03, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_rd   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    check_seq("rd4");

    // READ, len=0 at the top of the address space
    clear_logs();
    eng_lat = 0;
    push_n(4, 8'h00);
    rx_q.push_back(8'h77);
    issue(2'd0, 24'hFFFFFF, 16'd0);
    wait_done("rd1");
    exp_tx   = '{8'h03, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    exp_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_rd   = '{8'h77};
    check_seq("rd1");

    // PAGE_PROG, 2 bytes, WIP busy for two polls
    clear_logs();
    eng_lat = 2;
    wr_q.push_back(8'h5A); wr_q.push_back(8'hA5);
    wr_limit = 2;
    push_n(7, 8'h00);
    rx_q.push_back(8'h00); rx_q.push_back(8'h03);
    rx_q.push_back(8'h00); rx_q.push_back(8'h03);
    rx_q.push_back(8'h00); rx_q.push_back(8'h00);
    issue(2'd1, 24'h000100, 16'd1);
    wait_done("pp");
    exp_tx   = '{8'h06, 8'h02, 8'h00, 8'h01, 8'h00, 8'h5A, 8'hA5,
                 8'h05, 8'h00, 8'h05, 8'h00, 8'h05, 8'h00};
    exp_last = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    check_seq("pp");
    check("pp_wr_ready", wr_cnt, 2);
    check("pp_err", err, 0);

    // SECTOR_ERASE, with a stray cmd_valid while busy
    clear_logs();
    eng_lat = 1;
    issue(2'd2, 24'h010000, 16'd0);
    cmd_op    = 2'd0;
    cmd_addr  = 24'hABCDEF;
    cmd_valid = 1'b1;
    tick();
    check("se_busy_ready", cmd_ready, 0);
    tick();
    tick();
    cmd_valid = 1'b0;
    wait_done("se");
    exp_tx   = '{8'h06, 8'hD8, 8'h01, 8'h00, 8'h00, 8'h05, 8'h00};
    exp_last = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    check_seq("se");
    check("se_err", err, 0);

    // PAGE_PROG with wr_valid withheld after the first byte; len upper bits ignored
    clear_logs();
    eng_lat = 1;
    wr_q.push_back(8'h11); wr_q.push_back(8'h22); wr_q.push_back(8'h33);
    wr_limit = 1;
    issue(2'd1, 24'h00ABCD, 16'h0302);
    k = 0;
    while (tx_log.size() < 6 && k < 200) begin
      tick();
      k++;
    end
    check("stall_reach", tx_log.size(), 6);
    stall_bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (eng_req !== 1'b0 || eng_last !== 1'b0 || busy !== 1'b1) stall_bad++;
    end
    check("stall_quiet", stall_bad, 0);
    wr_limit = 3;
    wait_done("stall");
    exp_tx   = '{8'h06, 8'h02, 8'h00, 8'hAB, 8'hCD, 8'h11, 8'h22, 8'h33, 8'h05, 8'h00};
    exp_last = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    check_seq("stall");
    check("stall_wr_ready", wr_cnt, 3);

    // rst while the A1 byte is outstanding
    clear_logs();
    eng_lat = 2;
    issue(2'd0, 24'h012345, 16'd3);
    k = 0;
    while (!(eng_req && eng_tx == 8'h23) && k < 200) begin
      tick();
      k++;
    end
    check("mid_rst_a1", eng_tx, 8'h23);
    rst_test = 1'b1;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req", eng_req, 0);
    check("mid_rst_ready", cmd_ready, 1);
    tick();
    tick();
    rst_test = 1'b0;

    // READ_SR after the reset
    clear_logs();
    eng_lat = 3;
    rx_q.push_back(8'h00);
    rx_q.push_back(8'h5C);
    issue(2'd3, 24'h000000, 16'd0);
    wait_done("rdsr");
    exp_tx   = '{8'h05, 8'h00};
    exp_last = '{1'b0, 1'b1};
    exp_rd   = '{8'h5C};
    check_seq("rdsr");

`ifdef SEQ_TIMEOUT_EN
    // WIP stuck: five polls, then err and done
    clear_logs();
    eng_lat   = 0;
    wip_stuck = 1'b1;
    issue(2'd2, 24'h020000, 16'd0);
    wait_done("tmo");
    exp_tx   = '{8'h06, 8'hD8, 8'h02, 8'h00, 8'h00};
    exp_last = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      exp_tx.push_back(8'h05);   exp_last.push_back(1'b0);
      exp_tx.push_back(8'h00);   exp_last.push_back(1'b1);
    end
    check_seq("tmo");
    check("tmo_err", err, 1);

    clear_logs();
    issue(2'd3, 24'h000000, 16'd0);
    check("tmo_err_clr", err, 0);
    wait_done("tmo_rdsr");
    exp_tx   = '{8'h05, 8'h00};
    exp_last = '{1'b0, 1'b1};
    exp_rd   = '{8'h01};
    check_seq("tmo_rdsr");
    wip_stuck = 1'b0;
`endif

    check("handshake", hs_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
